// File: rtl/rx_front_pkg.sv
// Shared widths, settings offsets and the round/shift/saturate helper for the
// rx_decim_front receive path.
package rx_front_pkg;
  localparam int ADC_W     = 12;
  localparam int ACC_W     = 21;
  localparam int OUT_W     = 16;
  localparam int RATE_W    = 8;
  localparam int SHIFT_W   = 4;
  localparam int RATE_OFS  = 0;
  localparam int SHIFT_OFS = 1;

  localparam logic [SHIFT_W-1:0] SHIFT_MAX = 4'd8;
  localparam logic signed [ACC_W:0] SAT_MAX = 22'sd32767;
  localparam logic signed [ACC_W:0] SAT_MIN = -22'sd32768;

  function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] s);
    return (s > SHIFT_MAX) ? SHIFT_MAX : s;
  endfunction

  // One guard bit above the accumulator so the rounding bias cannot wrap.
  function automatic logic [OUT_W-1:0] round_sat(input logic signed [ACC_W-1:0] v,
                                                 input logic [SHIFT_W-1:0]      sh);
    logic signed [ACC_W:0] bias;
    logic signed [ACC_W:0] r;
    bias = '0;
    if (sh != '0) bias = $signed({{ACC_W{1'b0}}, 1'b1} << (sh - 4'd1));
    r = $signed({v[ACC_W-1], v}) + bias;
    r = r >>> sh;
    if (r > SAT_MAX) r = SAT_MAX;
    else if (r < SAT_MIN) r = SAT_MIN;
    return r[OUT_W-1:0];
  endfunction
endpackage

// File: rtl/rx_accum_dump.sv
// One channel: input register (with DC removal when RX_DC_OFFSET_EN is defined),
// integrate-and-dump accumulator, and the rounded/saturated output register.
module rx_accum_dump
  import rx_front_pkg::*;
(
  input  logic               rx_clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               restart,
  input  logic               acc_en,
  input  logic               dump,
  input  logic               out_en,
  input  logic [SHIFT_W-1:0] shift,
  input  logic [ADC_W-1:0]   x_in,
  output logic [OUT_W-1:0]   ch
);
  logic signed [ADC_W-1:0] x_q, x_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, pre_q, pre_d, xe;
  logic [OUT_W-1:0]        ch_q, ch_d;

`ifdef RX_DC_OFFSET_EN
  logic signed [23:0]    dc_q, dc_d;
  logic signed [ADC_W:0] diff;

  // Leaky estimator: dc_q/4096 tracks the input mean, x_d is the corrected sample.
  always_comb begin
    diff = $signed({x_in[ADC_W-1], x_in}) - $signed({dc_q[23], dc_q[23:12]});
    if (diff > 13'sd2047) x_d = 12'sd2047;
    else if (diff < -13'sd2048) x_d = -12'sd2048;
    else x_d = diff[ADC_W-1:0];
    dc_d = dc_q;
    if (restart) dc_d = '0;
    else if (enable) dc_d = dc_q + $signed({{(24-ADC_W){x_d[ADC_W-1]}}, x_d});
  end

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) dc_q <= '0;
    else          dc_q <= dc_d;
  end
`else
  logic unused_dc;
  assign unused_dc = enable;
  assign x_d = x_in;
`endif

  always_comb begin
    acc_d = acc_q;
    pre_d = pre_q;
    ch_d  = ch_q;
    xe    = {{(ACC_W-ADC_W){x_q[ADC_W-1]}}, x_q};
    if (restart || !acc_en) begin
      acc_d = '0;
    end else if (dump) begin
      pre_d = acc_q + xe;
      acc_d = '0;
    end else begin
      acc_d = acc_q + xe;
    end
    if (out_en) ch_d = round_sat(pre_q, shift);
  end

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q   <= '0;
      acc_q <= '0;
      pre_q <= '0;
      ch_q  <= '0;
    end else begin
      x_q   <= x_d;
      acc_q <= acc_d;
      pre_q <= pre_d;
      ch_q  <= ch_d;
    end
  end

  assign ch = ch_q;
endmodule

// File: rtl/rx_decim_front.sv
// Dual-channel ADC decimating front end: settings registers, shared dump counter,
// strobe pipeline and debug bus. DC removal is built in with RX_DC_OFFSET_EN.
module rx_decim_front
  import rx_front_pkg::*;
#(
  parameter logic [6:0]         BASE_ADDR = 7'd8,
  parameter logic [RATE_W-1:0]  RATE_RST  = 8'd0,
  parameter logic [SHIFT_W-1:0] SHIFT_RST = 4'd0
) (
  input  logic             rx_clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [ADC_W-1:0] rx_a_a,
  input  logic [ADC_W-1:0] rx_a_b,
  input  logic [6:0]       serial_addr,
  input  logic [31:0]      serial_data,
  input  logic             serial_strobe,
  output logic [OUT_W-1:0] ch_0,
  output logic [OUT_W-1:0] ch_1,
  output logic             rxstrobe,
  output logic [15:0]      debug_bus
);
  localparam logic [6:0] RATE_ADDR  = BASE_ADDR + 7'(RATE_OFS);
  localparam logic [6:0] SHIFT_ADDR = BASE_ADDR + 7'(SHIFT_OFS);

  logic [RATE_W-1:0]  rate_q, rate_d, cnt_q, cnt_d;
  logic [SHIFT_W-1:0] shift_q, shift_d, shift_eff;
  logic               en_q, en_d, dump_q, dump_d, stb_q, stb_d;
  logic               wr_rate, wr_shift, wr_any, dump;
  logic               unused_data;

  assign unused_data = ^serial_data[31:RATE_W];

  // en_q travels with the registered sample so enable gates exactly the samples it covered.
  always_comb begin
    wr_rate  = serial_strobe && (serial_addr == RATE_ADDR);
    wr_shift = serial_strobe && (serial_addr == SHIFT_ADDR);
    wr_any   = wr_rate || wr_shift;
    rate_d   = wr_rate  ? serial_data[RATE_W-1:0]  : rate_q;
    shift_d  = wr_shift ? serial_data[SHIFT_W-1:0] : shift_q;
    en_d     = enable;
    dump     = en_q && (cnt_q == '0) && !wr_any;
    if (wr_any || !en_q || (cnt_q == '0)) cnt_d = rate_d;
    else                                  cnt_d = cnt_q - 8'd1;
    dump_d   = dump;
    stb_d    = dump_q;
  end

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      rate_q  <= RATE_RST;
      shift_q <= SHIFT_RST;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      dump_q  <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      rate_q  <= rate_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      dump_q  <= dump_d;
      stb_q   <= stb_d;
    end
  end

  assign shift_eff = clamp_shift(shift_q);

  rx_accum_dump u_ch_a (
    .rx_clk  (rx_clk),
    .reset_n (reset_n),
    .enable  (enable),
    .restart (wr_any),
    .acc_en  (en_q),
    .dump    (dump),
    .out_en  (dump_q),
    .shift   (shift_eff),
    .x_in    (rx_a_a),
    .ch      (ch_0)
  );

  rx_accum_dump u_ch_b (
    .rx_clk  (rx_clk),
    .reset_n (reset_n),
    .enable  (enable),
    .restart (wr_any),
    .acc_en  (en_q),
    .dump    (dump),
    .out_en  (dump_q),
    .shift   (shift_eff),
    .x_in    (rx_a_b),
    .ch      (ch_1)
  );

  assign rxstrobe  = stb_q;
  assign debug_bus = {stb_q, enable, cnt_q, shift_q, 2'b00};
endmodule

// File: tb/tb_rx_decim_front.sv
// Self-checking bench for rx_decim_front: block-sum reference model with randomized
// and directed stimulus. Honors RX_DC_OFFSET_EN for the DC-removal scenario.
module tb_rx_decim_front;
  localparam int BASE = 8;

  logic        rx_clk, reset_n, enable, serial_strobe, rxstrobe;
  logic [11:0] rx_a_a, rx_a_b;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic [15:0] ch_0, ch_1, debug_bus;

  int n_vec, n_err, edge_n;
  int rate_m, shift_m, len_m, sum_a, sum_b, prev_a, prev_b, dc_a, dc_b;
  bit prev_en;
  typedef struct { int due; int a; int b; } pend_t;
  pend_t pq[$];
  logic        exp_stb;
  logic [15:0] exp_c0, exp_c1;

  rx_decim_front #(.BASE_ADDR(7'd8), .RATE_RST(8'd0), .SHIFT_RST(4'd0)) dut (
    .rx_clk(rx_clk), .reset_n(reset_n), .enable(enable),
    .rx_a_a(rx_a_a), .rx_a_b(rx_a_b),
    .serial_addr(serial_addr), .serial_data(serial_data), .serial_strobe(serial_strobe),
    .ch_0(ch_0), .ch_1(ch_1), .rxstrobe(rxstrobe), .debug_bus(debug_bus)
  );

  initial rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Block sum -> round half up, floor divide by 2^shift, clamp to 16 bits.
  function automatic int scale(int v, int sh_raw);
    int sh, d, t, q;
    sh = (sh_raw > 8) ? 8 : sh_raw;
    d  = 1 << sh;
    t  = v + ((sh > 0) ? d / 2 : 0);
    q  = (t >= 0) ? t / d : -((-t + d - 1) / d);
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q;
  endfunction

  function automatic int sat12(int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  task automatic model_reset();
    pq.delete();
    rate_m = 0; shift_m = 0; len_m = 0; sum_a = 0; sum_b = 0;
    prev_a = 0; prev_b = 0; prev_en = 0; dc_a = 0; dc_b = 0;
    exp_stb = 1'b0; exp_c0 = '0; exp_c1 = '0;
  endtask

  // Apply one sample cycle and advance the reference model; returns #1 after the edge.
  task automatic drive(input int a, input int b, input bit en, input bit wr,
                       input int addr, input int data);
    pend_t p;
    int xa, xb;
    bit hit;
    rx_a_a = 12'(a); rx_a_b = 12'(b); enable = en;
    serial_strobe = wr; serial_addr = 7'(addr); serial_data = 32'(data);
    @(posedge rx_clk);
    edge_n++;
    exp_stb = 1'b0;
    if (pq.size() > 0 && pq[0].due == edge_n) begin
      p = pq.pop_front();
      exp_stb = 1'b1;
      exp_c0 = 16'(scale(p.a, shift_m));
      exp_c1 = 16'(scale(p.b, shift_m));
    end
    hit = wr && (addr == BASE || addr == BASE + 1);
    if (!hit && prev_en) begin
      sum_a += prev_a; sum_b += prev_b; len_m++;
      if (len_m == rate_m + 1) begin
        pq.push_back('{edge_n + 1, sum_a, sum_b});
        len_m = 0; sum_a = 0; sum_b = 0;
      end
    end else begin
      len_m = 0; sum_a = 0; sum_b = 0;
    end
`ifdef RX_DC_OFFSET_EN
    xa = sat12(a - (dc_a >>> 12));
    xb = sat12(b - (dc_b >>> 12));
    if (hit) begin dc_a = 0; dc_b = 0; end
    else if (en) begin dc_a += xa; dc_b += xb; end
`else
    xa = a; xb = b;
`endif
    if (wr && addr == BASE)     rate_m  = data & 255;
    if (wr && addr == BASE + 1) shift_m = data & 15;
    prev_a = xa; prev_b = xb; prev_en = en;
    #1;
  endtask

  task automatic wr_reg(input int addr, input int data);
    drive(0, 0, 1'b0, 1'b1, addr, data);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; serial_strobe = 1'b0;
    rx_a_a = '0; rx_a_b = '0; serial_addr = '0; serial_data = '0;
    model_reset();
    repeat (2) @(posedge rx_clk);
    #1;
    n_vec++;
    if (ch_0 !== 16'd0 || ch_1 !== 16'd0 || rxstrobe !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out: got ch0=%h ch1=%h stb=%b, want 0 0 0", ch_0, ch_1, rxstrobe);
    end
    n_vec++;
    if (debug_bus !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_debug: got %h want 0000", debug_bus);
    end
    @(negedge rx_clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int start, first, nstb;
    wr_reg(BASE + 1, 2);
    wr_reg(BASE, 3);
    start = edge_n + 1; first = -1; nstb = 0;
    for (int i = 0; i < 19; i++) begin
      drive(100, -100, i < 16, 1'b0, 0, 0);
      n_vec++;
      if (rxstrobe !== exp_stb || ch_0 !== exp_c0 || ch_1 !== exp_c1) begin
        n_err++;
        $display("FAIL basic e%0d: got stb=%b ch0=%0d ch1=%0d, want stb=%b ch0=%0d ch1=%0d",
                 edge_n, rxstrobe, $signed(ch_0), $signed(ch_1), exp_stb, $signed(exp_c0), $signed(exp_c1));
      end
      if (rxstrobe === 1'b1) begin
        nstb++;
        if (first < 0) first = edge_n;
      end
    end
    n_vec++;
    if (first != start + 5) begin
      n_err++;
      $display("FAIL basic_latency: first strobe at edge %0d, want %0d", first, start + 5);
    end
    n_vec++;
    if (nstb != 4) begin
      n_err++;
      $display("FAIL basic_count: got %0d strobes, want 4", nstb);
    end
    n_vec++;
    if (debug_bus[5:2] !== 4'd2) begin
      n_err++;
      $display("FAIL basic_debug_shift: got %0d want 2", debug_bus[5:2]);
    end
`ifndef RX_DC_OFFSET_EN
    n_vec++;
    if (ch_0 !== 16'd100 || ch_1 !== 16'hFF9C) begin
      n_err++;
      $display("FAIL basic_value: got ch0=%0d ch1=%0d, want 100 -100", $signed(ch_0), $signed(ch_1));
    end
`endif
  endtask

  task automatic test_saturation();
    wr_reg(BASE + 1, 0);
    wr_reg(BASE, 255);
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 259; i++) begin
        drive(pass == 0 ? 2047 : -2048, pass == 0 ? -2048 : 2047, i < 256, 1'b0, 0, 0);
        n_vec++;
        if (rxstrobe !== exp_stb || ch_0 !== exp_c0 || ch_1 !== exp_c1) begin
          n_err++;
          $display("FAIL saturation e%0d: got stb=%b ch0=%0d ch1=%0d, want stb=%b ch0=%0d ch1=%0d",
                   edge_n, rxstrobe, $signed(ch_0), $signed(ch_1), exp_stb, $signed(exp_c0), $signed(exp_c1));
        end
      end
`ifndef RX_DC_OFFSET_EN
      n_vec++;
      if (ch_0 !== (pass == 0 ? 16'h7FFF : 16'h8000)) begin
        n_err++;
        $display("FAIL saturation_value pass %0d: got ch0=%0d", pass, $signed(ch_0));
      end
`endif
    end
  endtask

  task automatic test_rounding();
    int va[8];
    int vb[8];
    va = '{1, 2, 0, 0, -1, -2, 0, 0};
    vb = '{5, 6, 0, 0, -5, -6, 0, 0};
    wr_reg(BASE + 1, 1);
    wr_reg(BASE, 1);
    for (int i = 0; i < 8; i++) begin
      drive(va[i], vb[i], (i % 4) < 2, 1'b0, 0, 0);
      n_vec++;
      if (rxstrobe !== exp_stb || ch_0 !== exp_c0 || ch_1 !== exp_c1) begin
        n_err++;
        $display("FAIL rounding e%0d: got stb=%b ch0=%0d ch1=%0d, want stb=%b ch0=%0d ch1=%0d",
                 edge_n, rxstrobe, $signed(ch_0), $signed(ch_1), exp_stb, $signed(exp_c0), $signed(exp_c1));
      end
`ifndef RX_DC_OFFSET_EN
      if (i == 3 || i == 7) begin
        n_vec++;
        if (ch_0 !== (i == 3 ? 16'd2 : 16'hFFFF)) begin
          n_err++;
          $display("FAIL rounding_value i%0d: got ch0=%0d, want %0d", i, $signed(ch_0), i == 3 ? 2 : -1);
        end
      end
`endif
    end
  endtask

  task automatic test_midblock_write();
    int start;
    wr_reg(BASE + 1, 1);
    wr_reg(BASE, 3);
    for (int i = 0; i < 17; i++) begin
      if (i == 6) start = edge_n + 1;
      drive(7 + i, -7 - i, 1'b1, i == 6, BASE, 0);
      n_vec++;
      if (rxstrobe !== exp_stb || ch_0 !== exp_c0 || ch_1 !== exp_c1) begin
        n_err++;
        $display("FAIL midblock e%0d: got stb=%b ch0=%0d ch1=%0d, want stb=%b ch0=%0d ch1=%0d",
                 edge_n, rxstrobe, $signed(ch_0), $signed(ch_1), exp_stb, $signed(exp_c0), $signed(exp_c1));
      end
      // The partial block (samples 5,6) must not produce a strobe at start+1.
      if (edge_n == start + 1) begin
        n_vec++;
        if (rxstrobe !== 1'b0) begin
          n_err++;
          $display("FAIL midblock_partial: got stb=%b want 0", rxstrobe);
        end
      end
    end
`ifndef RX_DC_OFFSET_EN
    n_vec++;
    if (ch_0 !== 16'd11) begin
      n_err++;
      $display("FAIL midblock_value: got ch0=%0d want 11", $signed(ch_0));
    end
`endif
  endtask

  task automatic test_enable_gap();
    int start, first;
    wr_reg(BASE + 1, 0);
    wr_reg(BASE, 2);
    first = -1; start = 0;
    for (int i = 0; i < 28; i++) begin
      if (i == 17) start = edge_n + 1;
      drive(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
            (i < 7) || (i >= 17), 1'b0, 0, 0);
      n_vec++;
      if (rxstrobe !== exp_stb || ch_0 !== exp_c0 || ch_1 !== exp_c1) begin
        n_err++;
        $display("FAIL enable_gap e%0d: got stb=%b ch0=%0d ch1=%0d, want stb=%b ch0=%0d ch1=%0d",
                 edge_n, rxstrobe, $signed(ch_0), $signed(ch_1), exp_stb, $signed(exp_c0), $signed(exp_c1));
      end
      if (i >= 17 && rxstrobe === 1'b1 && first < 0) first = edge_n;
    end
    n_vec++;
    if (first != start + 4) begin
      n_err++;
      $display("FAIL enable_resume: first strobe at edge %0d, want %0d", first, start + 4);
    end
  endtask

  task automatic test_reset_midblock();
    int start, first;
    wr_reg(BASE, 3);
    drive(300, 300, 1'b1, 1'b0, 0, 0);
    drive(300, 300, 1'b1, 1'b0, 0, 0);
    reset_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (ch_0 !== 16'd0 || ch_1 !== 16'd0 || rxstrobe !== 1'b0) begin
        n_err++;
        $display("FAIL reset_mid %0d: got ch0=%h ch1=%h stb=%b, want 0 0 0", i, ch_0, ch_1, rxstrobe);
      end
      @(posedge rx_clk);
      #1;
    end
    @(negedge rx_clk);
    reset_n = 1'b1;
    wr_reg(BASE, 3);
    start = edge_n + 1; first = -1;
    for (int i = 0; i < 8; i++) begin
      drive(40, 80, 1'b1, 1'b0, 0, 0);
      n_vec++;
      if (rxstrobe !== exp_stb || ch_0 !== exp_c0 || ch_1 !== exp_c1) begin
        n_err++;
        $display("FAIL reset_resume e%0d: got stb=%b ch0=%0d ch1=%0d, want stb=%b ch0=%0d ch1=%0d",
                 edge_n, rxstrobe, $signed(ch_0), $signed(ch_1), exp_stb, $signed(exp_c0), $signed(exp_c1));
      end
      if (rxstrobe === 1'b1 && first < 0) first = edge_n;
    end
    n_vec++;
    if (first != start + 5) begin
      n_err++;
      $display("FAIL reset_first_strobe: at edge %0d, want %0d", first, start + 5);
    end
  endtask

  task automatic test_random();
    int addr, data;
    bit wr;
    for (int i = 0; i < 900; i++) begin
      wr   = ($urandom_range(0, 24) == 0);
      addr = 7 + int'($urandom_range(0, 3));
      data = (addr == BASE) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 15));
      drive(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
            $urandom_range(0, 15) != 0, wr, addr, data);
      n_vec++;
      if (rxstrobe !== exp_stb || ch_0 !== exp_c0 || ch_1 !== exp_c1) begin
        n_err++;
        $display("FAIL random e%0d: got stb=%b ch0=%0d ch1=%0d, want stb=%b ch0=%0d ch1=%0d",
                 edge_n, rxstrobe, $signed(ch_0), $signed(ch_1), exp_stb, $signed(exp_c0), $signed(exp_c1));
      end
    end
  endtask

  task automatic test_dc();
    int last;
    wr_reg(BASE + 1, 0);
    wr_reg(BASE, 0);
`ifdef RX_DC_OFFSET_EN
    last = 32767;
    for (int i = 0; i < 40000; i++) begin
      drive(500, -500, 1'b1, 1'b0, 0, 0);
      n_vec++;
      if (rxstrobe !== exp_stb || ch_0 !== exp_c0 || ch_1 !== exp_c1) begin
        n_err++;
        $display("FAIL dc_model e%0d: got stb=%b ch0=%0d ch1=%0d, want stb=%b ch0=%0d ch1=%0d",
                 edge_n, rxstrobe, $signed(ch_0), $signed(ch_1), exp_stb, $signed(exp_c0), $signed(exp_c1));
      end
      if (rxstrobe === 1'b1) begin
        n_vec++;
        if (int'($signed(ch_0)) > last) begin
          n_err++;
          $display("FAIL dc_monotonic e%0d: got ch0=%0d after %0d", edge_n, $signed(ch_0), last);
        end
        last = int'($signed(ch_0));
      end
    end
    n_vec++;
    if (int'($signed(ch_0)) > 2 || int'($signed(ch_0)) < -2) begin
      n_err++;
      $display("FAIL dc_settle: got ch0=%0d, want within +-2", $signed(ch_0));
    end
`else
    last = 0;
    for (int i = 0; i < 60; i++) begin
      drive(500, -500, 1'b1, 1'b0, 0, 0);
      n_vec++;
      if (rxstrobe !== exp_stb || ch_0 !== exp_c0 || ch_1 !== exp_c1) begin
        n_err++;
        $display("FAIL dc_off e%0d: got stb=%b ch0=%0d ch1=%0d, want stb=%b ch0=%0d ch1=%0d",
                 edge_n, rxstrobe, $signed(ch_0), $signed(ch_1), exp_stb, $signed(exp_c0), $signed(exp_c1));
      end
      if (rxstrobe === 1'b1) last++;
    end
    n_vec++;
    if (ch_0 !== 16'd500 || last != 58) begin
      n_err++;
      $display("FAIL dc_off_value: got ch0=%0d strobes=%0d, want 500 58", $signed(ch_0), last);
    end
`endif
  endtask

  initial begin
    n_vec = 0; n_err = 0; edge_n = 0;
    test_reset();
    test_basic();
    test_saturation();
    test_rounding();
    test_midblock_write();
    test_enable_gap();
    test_reset_midblock();
    test_random();
    test_dc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rx_decim_front.md
Name: rx_decim_front

Overview:
- Receive front end between the dual 12-bit ADC bus (rx_a_a / rx_a_b) and rx_buffer.
- Conditions both channels, then integrate-and-dump decimates by a programmable rate.
- Rounds, shifts and saturates the result to 16 bits.
- Drives ch_0/ch_1 plus a one-cycle rxstrobe into rx_buffer. Rate and shift are written over the existing serial_addr/serial_data/serial_strobe settings bus.

Parameters:
- BASE_ADDR, 7'd8: settings address of the rate register. BASE_ADDR+1 is the shift register.
- RATE_RST, 8'd0: reset value of the rate register. Decimation factor = rate+1.
- SHIFT_RST, 4'd0: reset value of the shift register.

Ports:
- rx_clk  in  1  clk64 domain, shared with rx_buffer
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  run/hold
- rx_a_a  in  12  channel A ADC sample, two's complement, new sample every clock
- rx_a_b  in  12  channel B ADC sample, two's complement
- serial_addr  in  7  settings address
- serial_data  in  32  settings data
- serial_strobe  in  1  one-cycle settings write
- ch_0  out  16  decimated channel A
- ch_1  out  16  decimated channel B
- rxstrobe  out  1  one-cycle pulse, ch_0/ch_1 valid
- debug_bus  out  16  {rxstrobe, enable, cnt[7:0], shift[3:0], 2'b0}

Behaviour:
- Reset (reset_n low, async):
  - ch_0=0, ch_1=0, rxstrobe=0.
  - rate=RATE_RST, shift=SHIFT_RST.
  - Counter and accumulators = 0; input registers = 0.
- Stage 1: rx_a_a/rx_a_b registered every clock. Optional DC removal is applied here.
- Stage 2 (per channel):
  - 21-bit signed accumulator; down-counter cnt, shared by both channels.
  - cnt==0 with enable high: dump. out_pre = acc + x. acc <= 0. cnt <= rate.
  - Otherwise: acc <= acc + x. cnt <= cnt-1.
- Output stage, on dump:
  - If shift>0, add 2^(shift-1) (round half up); then arithmetic right shift by shift.
  - Saturate to [-32768, 32767] and register into ch_0/ch_1.
  - rxstrobe high for exactly that one cycle.
- Latency: rxstrobe and ch_x update 3 rx_clk edges after the final contributing sample is on the ports.
- ch_x hold their value between strobes.
- Minimum strobe spacing is rate+1 cycles. rate=0 gives a strobe every cycle, i.e. pass-through with shift/saturate.
- Width: the worst case (rate=255, shift=0, input -2048) sums to -524288, which fits in 21 bits. Saturation is applied only after the shift.
- shift values 9..15 are clamped to 8.
- Settings writes:
  - serial_strobe with serial_addr==BASE_ADDR loads rate from serial_data[7:0].
  - serial_strobe with serial_addr==BASE_ADDR+1 loads shift from serial_data[3:0].
  - Any rate or shift write restarts decimation on the next cycle: acc cleared, cnt<=new rate, no strobe for the partial block.
  - Other addresses are ignored.
- enable low: acc and cnt held at 0/rate, no strobes, ch_x hold. On enable rising, the first strobe comes after rate+1 samples.
- enable low on the exact dump cycle: the dump is suppressed.
- reset_n asserted mid-block: everything returns to reset values immediately; no strobe is produced.

Optional Feature:
- Macro: RX_DC_OFFSET_EN.
- Defined: per-channel leaky DC estimator, 24-bit signed dc_acc.
  - corr = sat12(x - dc_acc[23:12]).
  - dc_acc <= dc_acc + corr each cycle while enable is high.
  - dc_acc is cleared on reset and on any settings write.
  - corr feeds the accumulator instead of x.
  - Latency is unchanged: the subtraction is in stage 1.
- Undefined: corr = x. No dc_acc registers are generated.

Decomposition:
- Package rx_front_pkg:
  - ADC_W=12, ACC_W=21, OUT_W=16, RATE_W=8, SHIFT_W=4, SHIFT_MAX=8.
  - Register offsets RATE_OFS=0, SHIFT_OFS=1.
  - SAT_MAX/SAT_MIN constants.
- Sub-module rx_accum_dump: one channel, covering accumulate, round, shift, saturate and optional DC removal. Instantiated twice.
- The top block owns the settings registers, cnt, rxstrobe and debug_bus.

Test Plan:
- rate=3, shift=2, rx_a_a=100 constant, rx_a_b=-100 → strobe every 4 cycles; ch_0=100, ch_1=-100. First strobe 3 edges after the 4th sample.
- rate=255, shift=0, rx_a_a=2047 constant → ch_0=32767 (saturated). With rx_a_a=-2048 → ch_0=-32768.
- rate=1, shift=1, samples 1,2 → sum 3, (3+1)>>1 → ch_0=2. Samples -1,-2 → (-3+1)>>>1 → ch_0=-1.
- Mid-block write rate=0 at sample 2 of 4 → no strobe for the partial block. Strobe every cycle afterwards, with ch_0 = round(x>>shift).
- enable deasserted for 10 cycles, or reset_n pulsed mid-block → no rxstrobe while disabled/reset; ch_x held, or 0 after reset; first strobe rate+1 samples after resume.
- RX_DC_OFFSET_EN: rx_a_a=500 constant, rate=0, shift=0 → ch_0 decays monotonically toward 0 and is within ±2 after 40000 cycles. Without the macro, ch_0 stays at 500.
